// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : core (package)
// Desc   : Shared types and constants for the instruction fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package core;

    localparam logic [31:0] ILEN = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } if_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_if.sv
// ============================================================================
// Module : fetch_if
// Desc   : Control, instruction-memory and decode-stream signals of fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_if;

    logic        bubble;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        fetch_tvalid;
    logic        fetch_tready;
    logic [63:0] fetch_tdata;

    modport master (
        input  bubble, redirect_valid, redirect_pc, imem_rdata, fetch_tready,
        output imem_en, imem_addr, fetch_tvalid, fetch_tdata
    );

    modport slave (
        output bubble, redirect_valid, redirect_pc, imem_rdata, fetch_tready,
        input  imem_en, imem_addr, fetch_tvalid, fetch_tdata
    );

endinterface

`default_nettype wire

// File: rtl/fetch_skid.sv
// ============================================================================
// Module : skid
// Desc   : One-entry holding register for a response that meets a stalled
//          output register. Push wins over pop; flush clears the entry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module skid
    import core::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic flush,
    input  wire logic push,
    input  wire if_t  push_data,
    input  wire logic pop,
    output logic      valid,
    output if_t       data
);

    logic valid_q, valid_d;
    if_t  data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            data_d  = push_data;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

`default_nettype wire

// File: rtl/fetch.sv
// ============================================================================
// Module : fetch
// Desc   : Instruction fetch with RUN/HOLD control and an AXI-stream output.
//          Define FETCH_SKID_EN for a skid entry and one-per-cycle issue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch
    import core::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic clk,
    input  wire logic resetn,
    fetch_if.master   bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  iss_pc_q, iss_pc_d;
    logic         inflight_q, inflight_d;
    logic         out_valid_q, out_valid_d;
    if_t          out_q, out_d;

    logic kill, tvalid, accept, can_issue, issue;
    if_t  resp_data;

`ifdef FETCH_SKID_EN
    logic skid_valid, skid_push, skid_pop;
    if_t  skid_data;

    skid u_skid (
        .clk       (clk),
        .rst_n     (resetn),
        .flush     (kill),
        .push      (skid_push),
        .push_data (resp_data),
        .pop       (skid_pop),
        .valid     (skid_valid),
        .data      (skid_data)
    );
`endif

    always_comb begin
        // Anything other than plain RUN discards buffered and in-flight data.
        kill         = bus.redirect_valid | bus.bubble | (state_q == ST_HOLD);
        resp_data.pc = iss_pc_q;
        resp_data.ir = bus.imem_rdata;
        tvalid       = (out_valid_q | inflight_q) & ~kill;
        accept       = tvalid & bus.fetch_tready;
`ifdef FETCH_SKID_EN
        can_issue    = ~skid_valid & ~(inflight_q & out_valid_q & ~accept);
`else
        can_issue    = ~inflight_q & (~out_valid_q | accept);
`endif
        issue        = resetn & ~kill & can_issue;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        iss_pc_d    = iss_pc_q;
        inflight_d  = issue;
        out_valid_d = out_valid_q;
        out_d       = out_q;
`ifdef FETCH_SKID_EN
        skid_push   = 1'b0;
        skid_pop    = 1'b0;
`endif
        if (bus.redirect_valid) begin
            state_d = ST_RUN;
            pc_d    = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            if (bus.bubble) state_d = ST_HOLD;
            if (issue)      pc_d    = pc_q + ILEN;
        end
        if (issue) iss_pc_d = pc_q;

        // Order of age: output register, then skid entry, then the live response.
        if (kill) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            if (accept) begin
`ifdef FETCH_SKID_EN
                if (skid_valid) begin
                    out_d    = skid_data;
                    skid_pop = 1'b1;
                end else
`endif
                if (inflight_q) out_d       = resp_data;
                else            out_valid_d = 1'b0;
            end
`ifdef FETCH_SKID_EN
            else if (inflight_q) begin
                skid_push = 1'b1;
            end
`endif
        end else if (inflight_q && !accept) begin
            out_valid_d = 1'b1;
            out_d       = resp_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            iss_pc_q    <= '0;
            inflight_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            iss_pc_q    <= iss_pc_d;
            inflight_q  <= inflight_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    // A response not yet registered is forwarded straight from memory.
    assign bus.imem_en      = issue;
    assign bus.imem_addr    = pc_q;
    assign bus.fetch_tvalid = tvalid;
    assign bus.fetch_tdata  = out_valid_q ? out_q : (inflight_q ? resp_data : '0);

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// ============================================================================
// Module : tb_fetch
// Desc   : Directed per-cycle vector table for fetch plus reset sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch;

    typedef struct {
        logic        bub;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        en;
        logic [31:0] addr;
        logic        tv;
        logic [31:0] tpc;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fetch_if bus ();

    fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Instruction memory: data is the address xor 0xA5, one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= bus.imem_addr ^ 32'h0000_00A5;
    end

    function automatic void add(input int bub, input int rv, input logic [31:0] rpc,
                                input int rdy, input int en, input logic [31:0] addr,
                                input int tv, input logic [31:0] tpc);
        vec_t v;
        v.bub  = (bub != 0);
        v.rv   = (rv != 0);
        v.rpc  = rpc;
        v.rdy  = (rdy != 0);
        v.en   = (en != 0);
        v.addr = addr;
        v.tv   = (tv != 0);
        v.tpc  = tpc;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word(input logic [31:0] pc);
        return {pc, pc ^ 32'h0000_00A5};
    endfunction

    initial begin
        resetn             = 1'b0;
        bus.bubble         = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.fetch_tready   = 1'b1;

`ifdef FETCH_SKID_EN
        add(0,0,0,1, 1,'h100, 0,0);
        add(0,0,0,1, 1,'h104, 1,'h100);
        add(0,0,0,1, 1,'h108, 1,'h104);
        add(0,0,0,1, 1,'h10C, 1,'h108);
        add(0,0,0,1, 1,'h110, 1,'h10C);
        add(0,0,0,0, 1,'h114, 1,'h110);
        for (int k = 0; k < 4; k++) add(0,0,0,0, 0,0, 1,'h110);
        add(0,0,0,1, 0,0,     1,'h110);
        add(0,0,0,1, 1,'h118, 1,'h114);
        add(0,0,0,1, 1,'h11C, 1,'h118);
        add(0,0,0,1, 1,'h120, 1,'h11C);
`else
        add(0,0,0,1, 1,'h100, 0,0);
        add(0,0,0,1, 0,0,     1,'h100);
        add(0,0,0,1, 1,'h104, 0,0);
        add(0,0,0,1, 0,0,     1,'h104);
        add(0,0,0,1, 1,'h108, 0,0);
        add(0,0,0,1, 0,0,     1,'h108);
        add(0,0,0,1, 1,'h10C, 0,0);
        for (int k = 0; k < 5; k++) add(0,0,0,0, 0,0, 1,'h10C);
        add(0,0,0,1, 1,'h110, 1,'h10C);
        add(0,0,0,1, 0,0,     1,'h110);
        add(0,0,0,1, 1,'h114, 0,0);
        add(0,0,0,1, 0,0,     1,'h114);
`endif
        // Bubble at 0x20, hold, redirect to 0x80.
        add(0,1,'h20,1, 0,0,    0,0);
        add(0,0,0,1,    1,'h20, 0,0);
        add(1,0,0,1,    0,0,    0,0);
        add(0,0,0,1,    0,0,    0,0);
        add(1,0,0,1,    0,0,    0,0);
        add(0,1,'h80,1, 0,0,    0,0);
        add(0,0,0,1,    1,'h80, 0,0);
`ifdef FETCH_SKID_EN
        add(0,0,0,1,    1,'h84, 1,'h80);
`else
        add(0,0,0,1,    0,0,    1,'h80);
`endif
        // Redirect wins over bubble; low address bits dropped.
        add(1,1,'h43,1, 0,0,    0,0);
        add(0,0,0,1,    1,'h40, 0,0);
`ifdef FETCH_SKID_EN
        add(0,0,0,1,    1,'h44, 1,'h40);
`else
        add(0,0,0,1,    0,0,    1,'h40);
`endif
        // PC wrap at the top of the address space.
        add(0,1,'hFFFF_FFFC,1, 0,0, 0,0);
        add(0,0,0,1, 1,'hFFFF_FFFC, 0,0);
`ifdef FETCH_SKID_EN
        add(0,0,0,1, 1,0, 1,'hFFFF_FFFC);
        add(0,0,0,1, 1,4, 1,0);
`else
        add(0,0,0,1, 0,0, 1,'hFFFF_FFFC);
        add(0,0,0,1, 1,0, 0,0);
        add(0,0,0,1, 0,0, 1,0);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_imem_en", {63'd0, bus.imem_en}, 64'd0);
        chk("reset_tvalid",  {63'd0, bus.fetch_tvalid}, 64'd0);
        chk("reset_tdata",   bus.fetch_tdata, 64'd0);
        chk("reset_addr",    {32'd0, bus.imem_addr}, 64'h100);

        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) begin
                @(posedge clk); #1;
            end
            bus.bubble         = vecs[i].bub;
            bus.redirect_valid = vecs[i].rv;
            bus.redirect_pc    = vecs[i].rpc;
            bus.fetch_tready   = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_imem_en", i), {63'd0, bus.imem_en}, {63'd0, vecs[i].en});
            if (vecs[i].en)
                chk($sformatf("v%0d_imem_addr", i), {32'd0, bus.imem_addr}, {32'd0, vecs[i].addr});
            chk($sformatf("v%0d_tvalid", i), {63'd0, bus.fetch_tvalid}, {63'd0, vecs[i].tv});
            if (vecs[i].tv)
                chk($sformatf("v%0d_tdata", i), bus.fetch_tdata, word(vecs[i].tpc));
        end

        // Reset asserted with a response in flight and tvalid high.
        @(posedge clk); #1;
        bus.bubble         = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        bus.fetch_tready   = 1'b0;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("rst_seq_issue", {bus.imem_en, 31'd0, bus.imem_addr}, {1'b1, 31'd0, 32'h200});
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_seq_tvalid", {63'd0, bus.fetch_tvalid}, 64'd1);
        chk("rst_seq_tdata",  bus.fetch_tdata, word(32'h200));
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_async_en",     {63'd0, bus.imem_en}, 64'd0);
        chk("rst_async_tvalid", {63'd0, bus.fetch_tvalid}, 64'd0);
        chk("rst_async_tdata",  bus.fetch_tdata, 64'd0);
        @(posedge clk); #1;
        resetn           = 1'b1;
        bus.fetch_tready = 1'b1;
        @(negedge clk);
        chk("restart_issue", {bus.imem_en, 31'd0, bus.imem_addr}, {1'b1, 31'd0, 32'h100});
        @(posedge clk); #1;
        @(negedge clk);
        chk("restart_tvalid", {63'd0, bus.fetch_tvalid}, 64'd1);
        chk("restart_tdata",  bus.fetch_tdata, word(32'h100));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
